// File: rtl/uart_json_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_json_cmd_rx
// Brief    : 8N1 UART receiver feeding a JSON drive-command frame parser
//            ({"T":n,"L":x.xx,"R":x.xx}\n) with wheel-speed classification.
// Revision : 1.0 - initial release
// ============================================================================
module uart_json_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5_000_000,
    parameter int FAST_THRESH  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        cmd_valid,
    output logic [7:0]  cmd_t,
    output logic [15:0] cmd_l,
    output logic [15:0] cmd_r,
    output logic [2:0]  state_control,
    output logic        parse_err,
    output logic        frame_err
);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_tmo_w = $clog2(TIMEOUT_CLKS);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT_CLKS - 1);
    localparam logic signed [15:0] c_fast      = 16'(FAST_THRESH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {WAIT_OPEN, KEY_OQ, KEY_NAME, KEY_CQ, COLON,
                              VAL_SIGN, VAL_INT, VAL_FRAC, WAIT_NL} p_state_t;

    rx_state_t          r_rx_state, w_rx_state;
    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic [2:0]         r_bit_idx, w_bit_idx;
    logic [7:0]         r_shift, w_shift;
    logic               w_byte_stb, w_frame_err;

    p_state_t           r_p_state, w_p_state;
    logic [1:0]         r_key, w_key;
    logic [2:0]         r_seen, w_seen, w_seen_commit;
    logic               r_neg, w_neg;
    logic [13:0]        r_mag, w_mag;
    logic [6:0]         r_frac, w_frac;
    logic [1:0]         r_frac_cnt, w_frac_cnt;
    logic [7:0]         r_val_t, w_val_t;
    logic signed [15:0] r_val_l, w_val_l, r_val_r, w_val_r;
    logic [c_tmo_w-1:0] r_tmo, w_tmo;
    logic               w_cmd_valid, w_parse_err, w_err, w_commit, w_timeout;
    logic [2:0]         w_state_control;
    logic [3:0]         w_digit;
    logic               w_is_digit, w_is_minus, w_is_space;
    logic [16:0]        w_mag_mul;
    logic [19:0]        w_abs;
    logic [14:0]        w_abs_sat;
    logic signed [15:0] w_value;

    // ------------------------------------------------------------------ UART
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state;
            r_cnt      <= w_cnt;
            r_bit_idx  <= w_bit_idx;
            r_shift    <= w_shift;
        end
    end

    always_comb begin
        w_rx_state  = r_rx_state;
        w_cnt       = r_cnt + 1'b1;
        w_bit_idx   = r_bit_idx;
        w_shift     = r_shift;
        w_byte_stb  = 1'b0;
        w_frame_err = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_cnt = '0;
                if (r_rx_prev && !r_rx_sync) w_rx_state = RX_START;
            end
            RX_START: if (r_cnt == c_half_last) begin
                // a start bit that is high again at mid-bit was only a glitch
                w_cnt      = '0;
                w_bit_idx  = '0;
                w_rx_state = r_rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_cnt == c_bit_last) begin
                w_cnt     = '0;
                w_shift   = {r_rx_sync, r_shift[7:1]};
                w_bit_idx = r_bit_idx + 1'b1;
                if (r_bit_idx == 3'd7) w_rx_state = RX_STOP;
            end
            RX_STOP: if (r_cnt == c_bit_last) begin
                w_cnt       = '0;
                w_byte_stb  = r_rx_sync;
                w_frame_err = !r_rx_sync;
                w_rx_state  = RX_IDLE;
            end
            default: w_rx_state = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- parser
    assign w_digit    = r_shift[3:0];
    assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
    assign w_is_minus = (r_shift == 8'h2D) || (r_shift == 8'h96);
    assign w_is_space = (r_shift == 8'h20) && !(r_p_state inside {VAL_INT, VAL_FRAC})
                        && !(r_p_state == VAL_SIGN && r_neg);
    assign w_mag_mul  = 17'(r_mag) * 17'd10 + 17'(w_digit);
    assign w_abs      = 20'(r_mag) * 20'd100 + 20'(r_frac);
    assign w_abs_sat  = (w_abs > 20'd32767) ? 15'h7FFF : w_abs[14:0];
    assign w_value    = r_neg ? -$signed({1'b0, w_abs_sat}) : $signed({1'b0, w_abs_sat});
    assign w_timeout  = (r_p_state != WAIT_OPEN) && (r_tmo == c_tmo_last) && !w_byte_stb;

    always_comb begin
        w_p_state       = r_p_state;
        w_key           = r_key;
        w_seen          = r_seen;
        w_neg           = r_neg;
        w_mag           = r_mag;
        w_frac          = r_frac;
        w_frac_cnt      = r_frac_cnt;
        w_val_t         = r_val_t;
        w_val_l         = r_val_l;
        w_val_r         = r_val_r;
        w_tmo           = (r_tmo == c_tmo_last) ? r_tmo : r_tmo + 1'b1;
        w_cmd_valid     = 1'b0;
        w_parse_err     = 1'b0;
        w_state_control = state_control;
        w_err           = 1'b0;
        w_commit        = 1'b0;
        w_seen_commit   = r_seen | (3'b001 << r_key);
        if (w_byte_stb) begin
            w_tmo = '0;
            if (!w_is_space) begin
                case (r_p_state)
                    WAIT_OPEN: if (r_shift == 8'h7B) w_p_state = KEY_OQ;
                    KEY_OQ: if (r_shift == 8'h22) w_p_state = KEY_NAME; else w_err = 1'b1;
                    KEY_NAME: begin
                        case (r_shift)
                            8'h54:   w_key = 2'd0;
                            8'h4C:   w_key = 2'd1;
                            8'h52:   w_key = 2'd2;
                            default: w_err = 1'b1;
                        endcase
                        if (!w_err && r_seen[w_key]) w_err = 1'b1;
                        w_p_state = KEY_CQ;
                    end
                    KEY_CQ: if (r_shift == 8'h22) w_p_state = COLON; else w_err = 1'b1;
                    COLON: if (r_shift == 8'h3A) begin
                        w_p_state  = VAL_SIGN;
                        w_neg      = 1'b0;
                        w_mag      = '0;
                        w_frac     = '0;
                        w_frac_cnt = '0;
                    end else w_err = 1'b1;
                    VAL_SIGN: begin
                        if (w_is_minus && !r_neg && r_key != 2'd0) w_neg = 1'b1;
                        else if (w_is_digit) begin
                            w_mag     = 14'(w_digit);
                            w_p_state = VAL_INT;
                        end else w_err = 1'b1;
                    end
                    VAL_INT: begin
                        // magnitude is capped well above any value that survives saturation
                        if (w_is_digit) w_mag = (w_mag_mul > 17'd9999) ? 14'd9999 : w_mag_mul[13:0];
                        else if (r_shift == 8'h2E && r_key != 2'd0) w_p_state = VAL_FRAC;
                        else if (r_shift == 8'h2C || r_shift == 8'h7D) w_commit = 1'b1;
                        else w_err = 1'b1;
                    end
                    VAL_FRAC: begin
                        if (w_is_digit) begin
                            if (r_frac_cnt == 2'd0) begin
                                w_frac     = 7'(w_digit) * 7'd10;
                                w_frac_cnt = 2'd1;
                            end else if (r_frac_cnt == 2'd1) begin
                                w_frac     = r_frac + 7'(w_digit);
                                w_frac_cnt = 2'd2;
                            end
                        end else if (r_shift == 8'h2C || r_shift == 8'h7D) w_commit = 1'b1;
                        else w_err = 1'b1;
                    end
                    WAIT_NL: begin
                        if (r_shift == 8'h0A) begin
                            w_cmd_valid = 1'b1;
                            w_p_state   = WAIT_OPEN;
                            if (r_val_l == 16'sd0 && r_val_r == 16'sd0) w_state_control = 3'b000;
                            else if (r_val_l < 16'sd0 && r_val_r > 16'sd0) w_state_control = 3'b001;
                            else if (r_val_l > 16'sd0 && r_val_r < 16'sd0) w_state_control = 3'b010;
                            else if (r_val_l == r_val_r && r_val_l >= c_fast) w_state_control = 3'b011;
                            else if (r_val_l == r_val_r && r_val_l > 16'sd0) w_state_control = 3'b100;
                        end else if (r_shift != 8'h0D) w_err = 1'b1;
                    end
                    default: w_p_state = WAIT_OPEN;
                endcase
            end
            if (w_commit) begin
                case (r_key)
                    2'd0:    w_val_t = (r_mag > 14'd255) ? 8'd255 : r_mag[7:0];
                    2'd1:    w_val_l = w_value;
                    default: w_val_r = w_value;
                endcase
                w_seen = w_seen_commit;
                if (r_shift == 8'h2C) w_p_state = KEY_OQ;
                else if (w_seen_commit == 3'b111) w_p_state = WAIT_NL;
                else w_err = 1'b1;
            end
            // '{' always opens a fresh frame, whether expected or as a resync
            if (r_shift == 8'h7B) w_seen = 3'b000;
            if (w_err) begin
                w_parse_err = 1'b1;
                w_p_state   = (r_shift == 8'h7B) ? KEY_OQ : WAIT_OPEN;
            end
        end else if (w_frame_err) begin
            w_p_state = WAIT_OPEN;
        end else if (w_timeout) begin
            w_parse_err = 1'b1;
            w_p_state   = WAIT_OPEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_state     <= WAIT_OPEN;
            r_key         <= '0;
            r_seen        <= '0;
            r_neg         <= 1'b0;
            r_mag         <= '0;
            r_frac        <= '0;
            r_frac_cnt    <= '0;
            r_val_t       <= '0;
            r_val_l       <= '0;
            r_val_r       <= '0;
            r_tmo         <= '0;
            cmd_valid     <= 1'b0;
            cmd_t         <= '0;
            cmd_l         <= '0;
            cmd_r         <= '0;
            state_control <= 3'b000;
            parse_err     <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            r_p_state     <= w_p_state;
            r_key         <= w_key;
            r_seen        <= w_seen;
            r_neg         <= w_neg;
            r_mag         <= w_mag;
            r_frac        <= w_frac;
            r_frac_cnt    <= w_frac_cnt;
            r_val_t       <= w_val_t;
            r_val_l       <= w_val_l;
            r_val_r       <= w_val_r;
            r_tmo         <= w_tmo;
            cmd_valid     <= w_cmd_valid;
            state_control <= w_state_control;
            parse_err     <= w_parse_err;
            frame_err     <= w_frame_err;
            if (w_cmd_valid) begin
                cmd_t <= r_val_t;
                cmd_l <= r_val_l;
                cmd_r <= r_val_r;
            end
        end
    end
endmodule
`default_nettype wire
